// File: rtl/inst_encoder_if.sv
// inst_encoder_if: request/response bundle between an instruction source and inst_encoder
//   request : in_valid/in_ready handshake, in_fmt, in_opcode, in_funct7, in_rd, in_rs1, in_rs2, in_funct3, in_imm
//   response: out_valid/out_ready handshake, out_inst, out_addr, out_err, plus running err_cnt
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_cnt;
  modport master (
    output in_valid, in_fmt, in_opcode, in_funct7, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err, err_cnt
  );
  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct7, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err, err_cnt
  );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: RV32I field encoder feeding a 2-entry FIFO of {err, addr, inst}
//   clk/rst: clock and asynchronous active-high reset; clr: synchronous clear of FIFO, address and error count
//   bus    : slave side of inst_encoder_if (request in, encoded word + address + error flag out)
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  inst_encoder_if.slave bus
);
  logic [31:0] imm, enc_inst, addr;
  logic [6:0]  op, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3, fmt;
  logic        enc_err, shift, i_ok, b_ok, j_ok, push, pop, wp, rp;
  logic [1:0]  count;
  logic [7:0]  err_cnt;
  logic [64:0] mem [2];
  logic [64:0] head;
  assign imm = bus.in_imm;
  assign op  = bus.in_opcode;
  assign f7  = bus.in_funct7;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign f3  = bus.in_funct3;
  assign fmt = bus.in_fmt;
  // slli/srli/srai: funct7 occupies the upper immediate bits, only a 5-bit shamt is legal
  assign shift = op == 7'b0010011 && f3[1:0] == 2'b01;
  // an immediate fits when every bit above the encodable range matches the sign bit
  assign i_ok = &imm[31:11] || ~|imm[31:11];
  assign b_ok = (&imm[31:12] || ~|imm[31:12]) && !imm[0];
  assign j_ok = (&imm[31:20] || ~|imm[31:20]) && !imm[0];
  assign enc_inst =
    fmt == 3'd0 ? {f7, rs2, rs1, f3, rd, op} :
    fmt == 3'd1 ? (shift ? {f7, imm[4:0], rs1, f3, rd, op} : {imm[11:0], rs1, f3, rd, op}) :
    fmt == 3'd2 ? {imm[11:5], rs2, rs1, f3, imm[4:0], op} :
    fmt == 3'd3 ? {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op} :
    fmt == 3'd4 ? {imm[31:12], rd, op} :
    fmt == 3'd5 ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, op} :
    32'h0000_0013;
  assign enc_err =
    fmt == 3'd0 ? 1'b0 :
    fmt == 3'd1 ? (shift ? |imm[31:5] : !i_ok) :
    fmt == 3'd2 ? !i_ok :
    fmt == 3'd3 ? !b_ok :
    fmt == 3'd4 ? |imm[11:0] :
    fmt == 3'd5 ? !j_ok :
    1'b1;
  assign bus.in_ready  = count < 2'd2 && !clr && !rst;
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign head          = mem[rp];
  // count is cleared asynchronously, so outputs fall to zero the moment rst rises
  assign bus.out_valid = count != 2'd0;
  assign bus.out_inst  = bus.out_valid ? head[31:0] : '0;
  assign bus.out_addr  = bus.out_valid ? head[63:32] : '0;
  assign bus.out_err   = bus.out_valid && head[64];
  assign bus.err_cnt   = err_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count   <= '0;
      wp      <= 1'b0;
      rp      <= 1'b0;
      addr    <= BASE_ADDR;
      err_cnt <= '0;
    end else if (clr) begin
      count   <= '0;
      wp      <= 1'b0;
      rp      <= 1'b0;
      addr    <= BASE_ADDR;
      err_cnt <= '0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop) rp <= ~rp;
      if (push) begin
        wp   <= ~wp;
        addr <= addr + 32'd4;
        if (enc_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= {enc_err, addr, enc_inst};
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: vector table, directed corner sequences and randomized scoreboard for inst_encoder
module tb_inst_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  int total = 0;
  int passed = 0;
  inst_encoder_if bus ();
  inst_encoder dut (.clk(clk), .rst(rst), .clr(clr), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    req_t        r;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  vec_t tv [12];
  logic [64:0] q [$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic apply(input req_t r);
    bus.in_fmt    = r.fmt;
    bus.in_opcode = r.op;
    bus.in_funct7 = r.f7;
    bus.in_rd     = r.rd;
    bus.in_rs1    = r.rs1;
    bus.in_rs2    = r.rs2;
    bus.in_funct3 = r.f3;
    bus.in_imm    = r.imm;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    clr = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // reference: field placement by arithmetic, ranges checked as signed integer bounds
  function automatic logic [32:0] model(input req_t r);
    logic [31:0] i = r.imm;
    int s = $signed(r.imm);
    logic [31:0] rdop = 32'(r.rd) << 7 | 32'(r.op);
    logic [31:0] rs1f3 = 32'(r.rs1) << 15 | 32'(r.f3) << 12;
    logic [31:0] rs2f = 32'(r.rs2) << 20;
    case (r.fmt)
      3'd0: return {1'b0, 32'(r.f7) << 25 | rs2f | rs1f3 | rdop};
      3'd1: return (r.op == 7'h13 && (r.f3 == 3'd1 || r.f3 == 3'd5)) ?
                   {i >= 32, 32'(r.f7) << 25 | (i % 32) << 20 | rs1f3 | rdop} :
                   {s < -2048 || s > 2047, (i % 4096) << 20 | rs1f3 | rdop};
      3'd2: return {s < -2048 || s > 2047, (i / 32 % 128) << 25 | rs2f | rs1f3 | (i % 32) << 7 | 32'(r.op)};
      3'd3: return {s < -4096 || s > 4095 || i % 2 == 1,
                    (i / 4096 % 2) << 31 | (i / 32 % 64) << 25 | rs2f | rs1f3 | (i / 2 % 16) << 8 | (i / 2048 % 2) << 7 | 32'(r.op)};
      3'd4: return {i % 4096 != 0, i / 4096 * 4096 | rdop};
      3'd5: return {s < -(1 << 20) || s > (1 << 20) - 1 || i % 2 == 1,
                    (i / (1 << 20) % 2) << 31 | (i / 2 % 1024) << 21 | (i / 2048 % 2) << 20 | (i / 4096 % 256) << 12 | rdop};
      default: return {1'b1, 32'h0000_0013};
    endcase
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int sel = $urandom_range(0, 4);
    r.fmt = 3'($urandom_range(0, 7));
    r.op  = ($urandom_range(0, 3) == 0) ? 7'h13 : 7'($urandom);
    r.f7  = 7'($urandom);
    r.rd  = 5'($urandom);
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    r.f3  = 3'($urandom);
    r.imm = sel == 0 ? $urandom :
            sel == 1 ? 32'($urandom_range(0, 8191)) - 32'd4096 :
            sel == 2 ? ($urandom & 32'hFFFF_F000) :
            sel == 3 ? 32'($urandom_range(0, 63)) :
            32'($urandom_range(0, 2097151)) - 32'h0010_0000;
    return r;
  endfunction

  initial begin
    logic [32:0] e;
    logic [31:0] m_addr;
    int m_err;
    int exp_err;
    req_t cur;
    logic exp_ready, acc, pop;
    tv[0]  = '{'{3'd3, 7'h63, 7'h00, 5'd0, 5'd1, 5'd2, 3'd0, 32'h0000_0008}, 32'h0020_8463, 1'b0};
    tv[1]  = '{'{3'd5, 7'h6F, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800}, 32'h0010_00EF, 1'b0};
    tv[2]  = '{'{3'd1, 7'h13, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF}, 32'hFFF0_0093, 1'b0};
    tv[3]  = '{'{3'd4, 7'h37, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000}, 32'h1234_52B7, 1'b0};
    tv[4]  = '{'{3'd4, 7'h37, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5001}, 32'h1234_52B7, 1'b1};
    tv[5]  = '{'{3'd1, 7'h13, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800}, 32'h8000_0093, 1'b1};
    tv[6]  = '{'{3'd7, 7'h7F, 7'h55, 5'd9, 5'd3, 5'd4, 3'd6, 32'h0000_1234}, 32'h0000_0013, 1'b1};
    tv[7]  = '{'{3'd0, 7'h33, 7'h20, 5'd1, 5'd2, 5'd3, 3'd0, 32'hDEAD_BEEF}, 32'h4031_00B3, 1'b0};
    tv[8]  = '{'{3'd1, 7'h13, 7'h20, 5'd1, 5'd2, 5'd7, 3'd5, 32'h0000_0003}, 32'h4031_5093, 1'b0};
    tv[9]  = '{'{3'd1, 7'h13, 7'h20, 5'd1, 5'd2, 5'd0, 3'd5, 32'h0000_0020}, 32'h4001_5093, 1'b1};
    tv[10] = '{'{3'd2, 7'h23, 7'h00, 5'd0, 5'd1, 5'd2, 3'd2, 32'h0000_0008}, 32'h0020_A423, 1'b0};
    tv[11] = '{'{3'd3, 7'h63, 7'h00, 5'd0, 5'd1, 5'd2, 3'd0, 32'h0000_0009}, 32'h0020_8463, 1'b1};
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    apply(tv[0].r);

    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'd0);
    chk("rst_out_addr", bus.out_addr, 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    bus.out_ready = 1'b1;
    exp_err = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      apply(tv[i].r);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (tv[i].err) exp_err++;
      chk($sformatf("tv%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("tv%0d_inst", i), bus.out_inst, tv[i].inst);
      chk($sformatf("tv%0d_err", i), 32'(bus.out_err), 32'(tv[i].err));
      chk($sformatf("tv%0d_addr", i), bus.out_addr, 32'(i * 4));
      chk($sformatf("tv%0d_err_cnt", i), 32'(bus.err_cnt), 32'(exp_err));
    end

    do_reset();
    cur = '{3'd1, 7'h13, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0};
    apply(cur);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cur.rd = 5'd2;
    apply(cur);
    @(posedge clk);
    @(negedge clk);
    cur.rd = 5'd3;
    apply(cur);
    #1;
    chk("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
    chk("bp_head_rd", 32'(bus.out_inst[11:7]), 32'd1);
    chk("bp_head_addr", bus.out_addr, 32'h0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_second_rd", 32'(bus.out_inst[11:7]), 32'd2);
    chk("bp_second_addr", bus.out_addr, 32'h4);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("bp_third_rd", 32'(bus.out_inst[11:7]), 32'd3);
    chk("bp_third_addr", bus.out_addr, 32'h8);
    @(posedge clk);
    #1;
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    do_reset();
    apply('{3'd7, 7'h00, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0});
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("clr_pre_err_cnt", 32'(bus.err_cnt), 32'd2);
    clr = 1'b1;
    #1;
    chk("clr_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("clr_err_cnt", 32'(bus.err_cnt), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    apply('{3'd1, 7'h13, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0});
    @(posedge clk);
    #1;
    chk("clr_next_valid", 32'(bus.out_valid), 32'd1);
    chk("clr_next_addr", bus.out_addr, 32'h0);
    chk("clr_next_inst", bus.out_inst, 32'h0000_0093);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("arst_release_ready", 32'(bus.in_ready), 32'd1);

    do_reset();
    apply('{3'd7, 7'h00, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0});
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    repeat (254) @(posedge clk);
    #1;
    chk("sat_254", 32'(bus.err_cnt), 32'hFE);
    repeat (46) @(posedge clk);
    #1;
    chk("sat_300", 32'(bus.err_cnt), 32'hFF);

    do_reset();
    m_addr = 32'h0;
    m_err = 0;
    q.delete();
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      cur = rand_req();
      apply(cur);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 49) == 0);
      #1;
      exp_ready = q.size() < 2 && !clr;
      chk("rnd_in_ready", 32'(bus.in_ready), 32'(exp_ready));
      chk("rnd_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("rnd_err_cnt", 32'(bus.err_cnt), 32'(m_err));
      if (q.size() != 0) begin
        chk("rnd_out_inst", bus.out_inst, q[0][31:0]);
        chk("rnd_out_addr", bus.out_addr, q[0][63:32]);
        chk("rnd_out_err", 32'(bus.out_err), 32'(q[0][64]));
      end
      acc = bus.in_valid && exp_ready;
      pop = q.size() != 0 && bus.out_ready;
      @(posedge clk);
      if (clr) begin
        q.delete();
        m_addr = 32'h0;
        m_err = 0;
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) begin
          e = model(cur);
          q.push_back({e[32], m_addr, e[31:0]});
          m_addr += 32'd4;
          if (e[32] && m_err < 255) m_err++;
        end
      end
    end
    clr = 1'b0;
    bus.in_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, is the address assigned to the first instruction after reset or clear.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 clr  input  1  synchronous clear of address counter, FIFO and error counter.
REQ-005 in_valid  input  1  encode request valid.
REQ-006 in_ready  output  1  encoder can accept a request.
REQ-007 in_fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are invalid.
REQ-008 in_opcode/in_funct7  input  7 each; in_rd/in_rs1/in_rs2  input  5 each; in_funct3  input  3  instruction fields.
REQ-009 in_imm  input  32  immediate as a signed byte value (U: full 32-bit value).
REQ-010 out_valid  output  1  encoded instruction available.
REQ-011 out_ready  input  1  consumer accepts head entry.
REQ-012 out_inst  output  32  encoded RV32 instruction word.
REQ-013 out_addr  output  32  address assigned to out_inst.
REQ-014 out_err  output  1  immediate out of range, misaligned, or invalid format for this entry.
REQ-015 err_cnt  output  8  saturating count of accepted requests with error.

Function
REQ-016 The block SHALL hold a 2-entry FIFO of {inst, addr, err}; out_* SHALL reflect the head entry; out_valid SHALL equal (count != 0).
REQ-017 in_ready SHALL equal (count < 2) && !clr && !rst.
REQ-018 A request is accepted on a rising edge with in_valid && in_ready; it SHALL appear at out_* after that same edge when the FIFO was empty (1-cycle latency).
REQ-019 Pop occurs on out_valid && out_ready; a push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-020 Encoding SHALL follow RV32I field placement: R {f7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-021 For I format with op=7'b0010011 and f3 001/101, inst[31:25] SHALL be funct7 and inst[24:20] SHALL be imm[4:0]; error if imm[31:5] != 0.
REQ-022 Range/alignment errors: I and S when imm[31:11] is not all equal; B when imm[31:12] is not all equal or imm[0]=1; J when imm[31:20] is not all equal or imm[0]=1; U when imm[11:0] != 0; R never errs.
REQ-023 On an error the instruction SHALL still be encoded from the truncated immediate bits; err=1 in that entry.
REQ-024 For in_fmt 6/7 the entry SHALL be inst=32'h0000_0013 with err=1.
REQ-025 The address counter SHALL tag each accepted request with its current value, then advance by 4, wrapping modulo 2^32.
REQ-026 err_cnt SHALL increment on each accepted erroneous request and saturate at 8'hFF.
REQ-027 When clr=1 at an edge, it SHALL take priority: FIFO emptied, address counter := BASE_ADDR, err_cnt := 0; no push occurs that cycle and out_valid=0 after the edge.

Reset
REQ-028 While rst=1: FIFO count=0, out_valid=0, in_ready=0, address counter=BASE_ADDR, err_cnt=0, out_inst/out_addr=0, out_err=0.
REQ-029 Reset asserted mid-operation SHALL discard all FIFO contents immediately, without waiting for a clock edge.
REQ-030 After rst is deasserted, in_ready SHALL be 1 in the first cycle.

Verification
REQ-031 I-type: fmt=1, op=0x13, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF -> out_inst=0xFFF00093, out_addr=0x0, out_err=0, 1-cycle latency.
REQ-032 B-type: fmt=3, op=0x63, rs1=1, rs2=2, f3=0, imm=8 -> 0x00208463; J-type: fmt=5, op=0x6F, rd=1, imm=0x800 -> 0x001000EF at addr 0x4.
REQ-033 U-type: fmt=4, op=0x37, rd=5, imm=0x12345000 -> 0x123452B7, err=0; same request with imm=0x12345001 -> err=1, err_cnt=1.
REQ-034 Errors: I-type imm=0x800 -> out_err=1, out_inst=0x80000093 (rd=1); fmt=7 -> out_inst=0x00000013, out_err=1; 300 erroneous requests -> err_cnt=0xFF.
REQ-035 Backpressure: hold out_ready=0 and push 3 requests -> in_ready=0 after 2 are accepted (addresses 0x0, 0x4). Release out_ready -> outputs in order, third request tagged 0x8.
REQ-036 Reset/clear: assert clr with 2 entries queued and in_valid=1 -> out_valid=0, next accept tagged BASE_ADDR; assert rst asynchronously mid-stream -> out_valid drops before the next edge.
